i2c_master_arbiter: RTL and testbench
=====================================

Name: i2c_master_arbiter

Overview:
Shares the single i2c_master_control instance between NUM_REQ independent requesters, using round-robin arbitration. For each granted transfer it latches the requester's slave address, data byte and speed mode. It drives the master's start/slave_addr/data_in and its SCL/SDA timing configuration, waits for done, then returns a per-requester ack or error. It sits directly between the client blocks and i2c_master_control, which it sequences and configures.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIME_W, 16, width of the master timing config fields (cycles of clk)
TIMEOUT_CYC, 2_000_000, max cycles in BUSY before abort (20 ms at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset; one clock; reset is asynchronous and active-high
req  in  NUM_REQ  per-requester transfer request (level, held until ack/err)
req_addr  in  NUM_REQ*7  per-requester 7-bit slave address, packed, requester 0 in LSBs
req_data  in  NUM_REQ*8  per-requester data byte, packed
req_speed  in  NUM_REQ*2  per-requester mode: 0 standard, 1 fast, 2 fast-plus, 3 reserved
ack  out  NUM_REQ  one-cycle pulse: transfer done for that requester
err  out  NUM_REQ  one-cycle pulse: reserved speed or timeout
busy  out  1  high whenever state != IDLE
m_start  out  1  start pulse to master
m_slave_addr  out  7  to master slave_addr
m_data_in  out  8  to master data_in
m_done  in  1  master done
m_scl_low_time  out  TIME_W  to master
m_scl_high_time  out  TIME_W  to master
m_sda_hold_time  out  TIME_W  to master

Behaviour:
- Reset (async, rst=1): state IDLE, rr_ptr=0. ack/err/m_start=0. m_slave_addr/m_data_in=0. Timing outputs = standard-mode values. busy=0. Takes effect immediately mid-transfer; no ack/err is issued for the aborted transfer.
- Timing table (clk cycles): standard 500/500/30, fast 130/120/10, fast-plus 50/50/5 (low/high/hold).
- States: IDLE, ARB, LAUNCH, BUSY, DONE.
- IDLE: if any req bit is set, go to ARB.
- ARB (1 cycle): grant the first set req at or after rr_ptr (cyclic scan). Latch its addr/data/speed and the grant index.
  - If speed==3: set err_flag and go to DONE without starting the master.
  - Otherwise drive m_slave_addr, m_data_in and the timing outputs from the latched values, and go to LAUNCH.
- LAUNCH (1 cycle): m_start=1. Config outputs are already stable for at least 1 cycle beforehand. Clear the timeout counter. Go to BUSY.
- BUSY: m_start=0. m_done is ignored in the first BUSY cycle, which masks a stale done. Afterwards, m_done=1 goes to DONE.
  - The counter increments every cycle. Reaching TIMEOUT_CYC-1 sets err_flag and goes to DONE.
  - m_done and timeout in the same cycle: done wins, no error.
- DONE (1 cycle):
  - Pulse ack[grant] if !err_flag, otherwise pulse err[grant]. Never both.
  - rr_ptr = (grant+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - Clear err_flag, return to IDLE.
- Minimum latency from req to m_start: 3 cycles (IDLE→ARB→LAUNCH). Back-to-back transfers have 1 idle cycle between them.
- Dropping req after the grant is ignored: the transfer completes and ack still pulses. Changing payload after ARB has no effect.
- Config outputs hold their last values between transfers.
- Unused upper bits when NUM_REQ is not a power of 2: rr_ptr never exceeds NUM_REQ-1.

Decomposition:
- i2c_pkg gets:
  - the i2c_speed_e enum (STANDARD, FAST, FAST_PLUS, RSVD);
  - the timing constants per mode;
  - a function returning the low/high/hold triple for a mode;
  - the arbiter state enum.
- One sub-module, i2c_rr_picker: combinational round-robin first-set search over req from rr_ptr. It outputs a grant index and a valid flag.

Test Plan:
1. Single requester 0, addr 7'h50, data 8'hA5, speed fast. Required response:
   - m_start pulses 3 cycles after req, with m_slave_addr=7'h50, m_data_in=8'hA5 and timing 130/120/10;
   - after the master's done, ack[0] pulses once;
   - busy stays high from ARB until DONE.
2. All 4 req held continuously. Required response:
   - grants occur in order 0,1,2,3,0;
   - each ack arrives before the next m_start;
   - the third grant uses requester 2's addr/speed (fast-plus → 50/50/5).
3. req[1] uses speed=3. Required response:
   - err[1] pulses 2 cycles after ARB;
   - no m_start is issued and ack[1] stays 0.
4. The master never asserts done (TIMEOUT_CYC overridden to 100). Required response:
   - err pulses 100 cycles after LAUNCH;
   - the arbiter returns to IDLE and serves the next requester.
5. Assert rst in BUSY. Required response:
   - m_start=0, busy=0 and all ack/err=0 at once;
   - after release, the first grant goes to requester 0 (rr_ptr reset).
6. m_done held high from the previous transfer at LAUNCH. Required response: done is ignored in the first BUSY cycle, and ack appears only after a fresh done.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master arbiter: speed modes, arbiter
// states and the per-mode SCL/SDA timing table (in clk cycles).
package i2c_pkg;

    typedef enum logic [1:0] {
        STANDARD  = 2'd0,
        FAST      = 2'd1,
        FAST_PLUS = 2'd2,
        RSVD      = 2'd3
    } i2c_speed_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_BUSY   = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_e;

    localparam int unsigned CFG_W = 16;

    typedef struct packed {
        logic [CFG_W-1:0] low;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] hold;
    } i2c_timing_t;

    localparam logic [CFG_W-1:0] STD_LOW   = 16'd500;
    localparam logic [CFG_W-1:0] STD_HIGH  = 16'd500;
    localparam logic [CFG_W-1:0] STD_HOLD  = 16'd30;
    localparam logic [CFG_W-1:0] FAST_LOW  = 16'd130;
    localparam logic [CFG_W-1:0] FAST_HIGH = 16'd120;
    localparam logic [CFG_W-1:0] FAST_HOLD = 16'd10;
    localparam logic [CFG_W-1:0] FP_LOW    = 16'd50;
    localparam logic [CFG_W-1:0] FP_HIGH   = 16'd50;
    localparam logic [CFG_W-1:0] FP_HOLD   = 16'd5;

    // Reserved mode never launches, so it falls back to standard timing.
    function automatic i2c_timing_t speed_timing(input i2c_speed_e spd);
        i2c_timing_t t;
        case (spd)
            FAST:      t = {FAST_LOW, FAST_HIGH, FAST_HOLD};
            FAST_PLUS: t = {FP_LOW, FP_HIGH, FP_HOLD};
            default:   t = {STD_LOW, STD_HIGH, STD_HOLD};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin search: first set req bit at or after rr_ptr,
// scanning cyclically through NUM_REQ entries.
module i2c_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   grant,
    output logic               valid
);

    logic [PTR_W-1:0] grant_s;
    logic             valid_s;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        int pos;
        grant_s = {PTR_W{1'b0}};
        valid_s = 1'b0;
        pos     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos     = (int'(rr_ptr) + k >= NUM_REQ) ? int'(rr_ptr) + k - NUM_REQ
                                                    : int'(rr_ptr) + k;
            grant_s = req[pos] ? PTR_W'(pos) : grant_s;
            valid_s = valid_s | req[pos];
        end
    end

    assign grant = grant_s;
    assign valid = valid_s;

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one i2c_master_control between NUM_REQ requesters:
// grants, configures and starts the master, then reports ack or err per requester.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIME_W      = 16,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*7-1:0]  req_addr,
    input  logic [NUM_REQ*8-1:0]  req_data,
    input  logic [NUM_REQ*2-1:0]  req_speed,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    err,
    output logic                  busy,
    output logic                  m_start,
    output logic [6:0]            m_slave_addr,
    output logic [7:0]            m_data_in,
    input  logic                  m_done,
    output logic [TIME_W-1:0]     m_scl_low_time,
    output logic [TIME_W-1:0]     m_scl_high_time,
    output logic [TIME_W-1:0]     m_sda_hold_time
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PTR_W-1:0]   LAST_IDX     = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e          state_r;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [PTR_W-1:0]    grant_r;
    logic                err_flag_r;
    logic                first_busy_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [NUM_REQ-1:0]  ack_r;
    logic [NUM_REQ-1:0]  err_r;
    logic                busy_r;
    logic                m_start_r;
    logic [6:0]          m_slave_addr_r;
    logic [7:0]          m_data_in_r;
    logic [TIME_W-1:0]   scl_low_r;
    logic [TIME_W-1:0]   scl_high_r;
    logic [TIME_W-1:0]   sda_hold_r;

    logic [PTR_W-1:0]    pick_grant_s;
    logic                pick_valid_s;
    logic [6:0]          sel_addr_s;
    logic [7:0]          sel_data_s;
    i2c_speed_e          sel_speed_s;
    i2c_timing_t         sel_timing_s;

    i2c_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_grant_s),
        .valid  (pick_valid_s)
    );

    // Mux out the payload of the requester the picker currently selects.
    always_comb begin
        sel_addr_s  = 7'd0;
        sel_data_s  = 8'd0;
        sel_speed_s = STANDARD;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s  = (pick_grant_s == PTR_W'(i)) ? req_addr[i*7 +: 7] : sel_addr_s;
            sel_data_s  = (pick_grant_s == PTR_W'(i)) ? req_data[i*8 +: 8] : sel_data_s;
            sel_speed_s = (pick_grant_s == PTR_W'(i)) ? i2c_speed_e'(req_speed[i*2 +: 2])
                                                      : sel_speed_s;
        end
        sel_timing_s = speed_timing(sel_speed_s);
    end

    // Arbiter FSM with all outputs registered; ack/err/m_start are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            rr_ptr_r       <= {PTR_W{1'b0}};
            grant_r        <= {PTR_W{1'b0}};
            err_flag_r     <= 1'b0;
            first_busy_r   <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            ack_r          <= {NUM_REQ{1'b0}};
            err_r          <= {NUM_REQ{1'b0}};
            busy_r         <= 1'b0;
            m_start_r      <= 1'b0;
            m_slave_addr_r <= 7'd0;
            m_data_in_r    <= 8'd0;
            scl_low_r      <= TIME_W'(STD_LOW);
            scl_high_r     <= TIME_W'(STD_HIGH);
            sda_hold_r     <= TIME_W'(STD_HOLD);
        end else begin
            ack_r     <= {NUM_REQ{1'b0}};
            err_r     <= {NUM_REQ{1'b0}};
            m_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        state_r <= ST_ARB;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (!pick_valid_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        grant_r <= pick_grant_s;
                        if (sel_speed_s == RSVD) begin
                            err_flag_r <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            m_slave_addr_r <= sel_addr_s;
                            m_data_in_r    <= sel_data_s;
                            scl_low_r      <= TIME_W'(sel_timing_s.low);
                            scl_high_r     <= TIME_W'(sel_timing_s.high);
                            sda_hold_r     <= TIME_W'(sel_timing_s.hold);
                            cnt_r          <= {CNT_W{1'b0}};
                            state_r        <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    m_start_r    <= 1'b1;
                    first_busy_r <= 1'b1;
                    cnt_r        <= cnt_r + CNT_W'(1);
                    state_r      <= ST_BUSY;
                end
                ST_BUSY: begin
                    // The first BUSY cycle masks any done left over from a previous transfer.
                    first_busy_r <= 1'b0;
                    cnt_r        <= cnt_r + CNT_W'(1);
                    if (!first_busy_r && m_done) begin
                        state_r <= ST_DONE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        err_flag_r <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (err_flag_r) begin
                        err_r <= REQ_ONE << grant_r;
                    end else begin
                        ack_r <= REQ_ONE << grant_r;
                    end
                    rr_ptr_r   <= (grant_r == LAST_IDX) ? {PTR_W{1'b0}} : grant_r + PTR_W'(1);
                    err_flag_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    err_flag_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack             = ack_r;
    assign err             = err_r;
    assign busy            = busy_r;
    assign m_start         = m_start_r;
    assign m_slave_addr    = m_slave_addr_r;
    assign m_data_in       = m_data_in_r;
    assign m_scl_low_time  = scl_low_r;
    assign m_scl_high_time = scl_high_r;
    assign m_sda_hold_time = sda_hold_r;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: expected grants are queued as
// requests are raised and checked at each m_start and each ack/err pulse.
module tb_i2c_master_arbiter;

    localparam int N  = 4;
    localparam int TW = 16;
    localparam int TO = 100;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*7-1:0] req_addr;
    logic [N*8-1:0] req_data;
    logic [N*2-1:0] req_speed;
    logic [N-1:0]   ack;
    logic [N-1:0]   err;
    logic           busy;
    logic           m_start;
    logic [6:0]     m_slave_addr;
    logic [7:0]     m_data_in;
    logic           m_done;
    logic [TW-1:0]  m_scl_low_time;
    logic [TW-1:0]  m_scl_high_time;
    logic [TW-1:0]  m_sda_hold_time;

    typedef struct {
        int         idx;
        bit         is_err;
        logic [6:0] addr;
        logic [7:0] data;
        logic [1:0] spd;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    i2c_master_arbiter #(
        .NUM_REQ     (N),
        .TIME_W      (TW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_speed       (req_speed),
        .ack             (ack),
        .err             (err),
        .busy            (busy),
        .m_start         (m_start),
        .m_slave_addr    (m_slave_addr),
        .m_data_in       (m_data_in),
        .m_done          (m_done),
        .m_scl_low_time  (m_scl_low_time),
        .m_scl_high_time (m_scl_high_time),
        .m_sda_hold_time (m_sda_hold_time)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "bench watchdog expired");
    end

    // Reference timing table {low, high, hold} in clk cycles.
    function automatic logic [47:0] exp_timing(input logic [1:0] s);
        case (s)
            2'd1:    return {16'd130, 16'd120, 16'd10};
            2'd2:    return {16'd50, 16'd50, 16'd5};
            default: return {16'd500, 16'd500, 16'd30};
        endcase
    endfunction

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic [1:0] s);
        req_addr[i*7 +: 7]  = a;
        req_data[i*8 +: 8]  = d;
        req_speed[i*2 +: 2] = s;
    endtask

    task automatic push_exp(input int i, input bit is_err);
        exp_t e;
        e.idx    = i;
        e.is_err = is_err;
        e.addr   = req_addr[i*7 +: 7];
        e.data   = req_data[i*8 +: 8];
        e.spd    = req_speed[i*2 +: 2];
        sb.push_back(e);
    endtask

    // kind 0: wait for m_start; kind 1: wait for any ack/err. Counts m_start pulses seen.
    task automatic wait_event(input int kind, input int max_cyc, output bit found,
                              output int cyc, output int starts);
        found  = 1'b0;
        cyc    = 0;
        starts = 0;
        while (!found && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (m_start) starts++;
            found = (kind == 0) ? m_start : ((ack | err) != 4'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        req    = 4'd0;
        m_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, m_start, ack, err, m_slave_addr, m_data_in} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, m_start, ack, err, m_slave_addr, m_data_in});
        end
        n_tests++;
        if ({m_scl_low_time, m_scl_high_time, m_sda_hold_time} !== exp_timing(2'd0)) begin
            n_fail++;
            $display("FAIL reset_timing: got %h expected %h",
                     {m_scl_low_time, m_scl_high_time, m_sda_hold_time}, exp_timing(2'd0));
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        bit   busy_ok;
        exp_t e;
        set_req(0, 7'h50, 8'hA5, 2'd1);
        req = 4'b0001;
        push_exp(0, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({busy, m_start} !== 2'b10) begin
            n_fail++;
            $display("FAIL t1_arb: got busy/start %b expected 10", {busy, m_start});
        end
        busy_ok = 1'b1;
        @(negedge clk);
        busy_ok &= busy & ~m_start;
        @(negedge clk);
        busy_ok &= busy;
        e = sb[0];
        n_tests++;
        if ({m_start, m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time}
            !== {1'b1, e.addr, e.data, exp_timing(e.spd)}) begin
            n_fail++;
            $display("FAIL t1_start_cfg: got %h expected %h",
                     {m_start, m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time},
                     {1'b1, e.addr, e.data, exp_timing(e.spd)});
        end
        @(negedge clk);
        busy_ok &= busy & ~m_start;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        busy_ok &= busy & (ack == 4'd0);
        n_tests++;
        if (busy_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy_hold: got %b expected 1", busy_ok);
        end
        @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if ({ack, err, busy} !== {4'd1 << e.idx, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL t1_ack: got ack/err/busy %b expected %b",
                     {ack, err, busy}, {4'd1 << e.idx, 4'd0, 1'b0});
        end
        req = 4'd0;
        @(negedge clk);
        n_tests++;
        if (ack !== 4'd0) begin
            n_fail++;
            $display("FAIL t1_ack_pulse: got %b expected 0000", ack);
        end
    endtask

    task automatic test_round_robin();
        bit   found;
        int   cyc;
        int   starts;
        exp_t e;
        do_reset();
        set_req(0, 7'h10, 8'h01, 2'd0);
        set_req(1, 7'h21, 8'h12, 2'd1);
        set_req(2, 7'h32, 8'h23, 2'd2);
        set_req(3, 7'h43, 8'h34, 2'd1);
        for (int g = 0; g < 5; g++) push_exp(g % 4, 1'b0);
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_event(0, 10, found, cyc, starts);
            n_tests++;
            if (!found || sb.size() == 0) begin
                n_fail++;
                $display("FAIL rr_start_%0d: got no m_start expected one within 10 cycles", g);
                break;
            end
            e = sb[0];
            n_tests++;
            if ({m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time}
                !== {e.addr, e.data, exp_timing(e.spd)}) begin
                n_fail++;
                $display("FAIL rr_cfg_%0d: got %h expected %h", g,
                         {m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time},
                         {e.addr, e.data, exp_timing(e.spd)});
            end
            @(negedge clk);
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
            wait_event(1, 10, found, cyc, starts);
            e = sb.pop_front();
            n_tests++;
            if (!found || starts != 0 || {ack, err} !== {4'd1 << e.idx, 4'd0}) begin
                n_fail++;
                $display("FAIL rr_ack_%0d: got ack/err %b starts %0d expected %b starts 0", g,
                         {ack, err}, starts, {4'd1 << e.idx, 4'd0});
            end
            if (g == 4) req = 4'd0;
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got busy %b queue %0d expected 0 and 0", busy, sb.size());
        end
    endtask

    task automatic test_reserved_speed();
        bit   found;
        int   cyc;
        int   starts;
        exp_t e;
        do_reset();
        set_req(1, 7'h11, 8'h22, 2'd3);
        push_exp(1, 1'b1);
        req = 4'b0010;
        wait_event(1, 10, found, cyc, starts);
        e = sb.pop_front();
        n_tests++;
        if (!found || cyc != 3 || starts != 0 || {ack, err} !== {4'd0, 4'd1 << e.idx}) begin
            n_fail++;
            $display("FAIL rsvd_err: got ack/err %b at cycle %0d starts %0d expected %b at 3 starts 0",
                     {ack, err}, cyc, starts, {4'd0, 4'd1 << e.idx});
        end
        req = 4'd0;
        @(negedge clk);
        n_tests++;
        if ({ack, err, m_start} !== 9'd0) begin
            n_fail++;
            $display("FAIL rsvd_after: got %b expected 0", {ack, err, m_start});
        end
    endtask

    task automatic test_timeout();
        bit   found;
        int   cyc;
        int   starts;
        exp_t e;
        do_reset();
        set_req(2, 7'h2A, 8'h5C, 2'd2);
        set_req(3, 7'h3B, 8'h6D, 2'd0);
        push_exp(2, 1'b1);
        push_exp(3, 1'b0);
        req = 4'b1100;
        wait_event(0, 10, found, cyc, starts);
        e = sb[0];
        n_tests++;
        if (!found || {m_slave_addr, m_scl_low_time} !== {e.addr, 16'd50}) begin
            n_fail++;
            $display("FAIL to_start: got found %b cfg %h expected 1 %h",
                     found, {m_slave_addr, m_scl_low_time}, {e.addr, 16'd50});
        end
        wait_event(1, TO + 50, found, cyc, starts);
        e = sb.pop_front();
        n_tests++;
        if (!found || cyc != TO || {ack, err} !== {4'd0, 4'd1 << e.idx}) begin
            n_fail++;
            $display("FAIL to_err: got ack/err %b after %0d cycles expected %b after %0d",
                     {ack, err}, cyc, {4'd0, 4'd1 << e.idx}, TO);
        end
        req = 4'b1000;
        wait_event(0, 10, found, cyc, starts);
        e = sb[0];
        n_tests++;
        if (!found || {m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time}
            !== {e.addr, e.data, exp_timing(e.spd)}) begin
            n_fail++;
            $display("FAIL to_next_cfg: got %h expected %h",
                     {m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time},
                     {e.addr, e.data, exp_timing(e.spd)});
        end
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        wait_event(1, 10, found, cyc, starts);
        e = sb.pop_front();
        n_tests++;
        if (!found || {ack, err} !== {4'd1 << e.idx, 4'd0}) begin
            n_fail++;
            $display("FAIL to_next_ack: got %b expected %b", {ack, err}, {4'd1 << e.idx, 4'd0});
        end
        req = 4'd0;
    endtask

    task automatic test_reset_in_busy();
        bit   found;
        int   cyc;
        int   starts;
        exp_t e;
        do_reset();
        set_req(1, 7'h19, 8'h91, 2'd1);
        req = 4'b0010;
        wait_event(0, 10, found, cyc, starts);
        rst = 1'b1;
        #1;
        n_tests++;
        if (!found || {m_start, busy, ack, err} !== 10'd0) begin
            n_fail++;
            $display("FAIL rst_busy_async: got found %b start/busy/ack/err %b expected 1 and 0",
                     found, {m_start, busy, ack, err});
        end
        set_req(0, 7'h0C, 8'hC0, 2'd2);
        set_req(2, 7'h2C, 8'h2D, 2'd1);
        push_exp(0, 1'b0);
        push_exp(2, 1'b0);
        req = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            wait_event(0, 10, found, cyc, starts);
            e = sb[0];
            n_tests++;
            if (!found || {m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time}
                !== {e.addr, e.data, exp_timing(e.spd)}) begin
                n_fail++;
                $display("FAIL rst_grant_%0d: got %h expected %h", g,
                         {m_slave_addr, m_data_in, m_scl_low_time, m_scl_high_time, m_sda_hold_time},
                         {e.addr, e.data, exp_timing(e.spd)});
            end
            @(negedge clk);
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
            wait_event(1, 10, found, cyc, starts);
            e = sb.pop_front();
            n_tests++;
            if (!found || {ack, err} !== {4'd1 << e.idx, 4'd0}) begin
                n_fail++;
                $display("FAIL rst_ack_%0d: got %b expected %b", g, {ack, err}, {4'd1 << e.idx, 4'd0});
            end
            req[e.idx] = 1'b0;
        end
    endtask

    task automatic test_stale_done();
        bit   found;
        int   cyc;
        int   starts;
        exp_t e;
        do_reset();
        m_done = 1'b1;
        set_req(3, 7'h77, 8'h88, 2'd1);
        push_exp(3, 1'b0);
        req = 4'b1000;
        wait_event(0, 10, found, cyc, starts);
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL stale_start: got no m_start expected one within 10 cycles");
        end
        @(negedge clk);
        m_done = 1'b0;
        wait_event(1, 5, found, cyc, starts);
        n_tests++;
        if (found) begin
            n_fail++;
            $display("FAIL stale_masked: got ack/err %b expected none before fresh done", {ack, err});
        end
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        wait_event(1, 10, found, cyc, starts);
        e = sb.pop_front();
        n_tests++;
        if (!found || cyc != 1 || {ack, err} !== {4'd1 << e.idx, 4'd0}) begin
            n_fail++;
            $display("FAIL stale_fresh_ack: got %b at cycle %0d expected %b at 1",
                     {ack, err}, cyc, {4'd1 << e.idx, 4'd0});
        end
        req = 4'd0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 4'd0;
        req_addr  = 28'd0;
        req_data  = 32'd0;
        req_speed = 8'd0;
        m_done    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_reserved_speed();
        test_timeout();
        test_reset_in_busy();
        test_stale_done();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d pending entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
